// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 serial receiver driven by an oversample enable.
//
// The rx line is double-flopped into the clk_in domain, then a small FSM
// (IDLE -> START -> DATA -> STOP) walks through the frame one clken at a
// time. Start is confirmed at the middle of the start bit; every later bit
// is sampled one full bit period after the previous sample, so all samples
// land near bit centres. A completed byte is presented on dout with rdy.
// frame_err and overrun are sticky until the consumer pulses rdy_clr.

module uart_receiver #(
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk_in,
    input  logic       rst,
    input  logic       rx,
    input  logic       clken,
    output logic [7:0] dout,
    output logic       rdy,
    input  logic       rdy_clr,
    output logic       frame_err,
    output logic       overrun,
    output logic       rx_busy
);

    // Counter is sized so that it wraps exactly once per bit period.
    localparam int CW = $clog2(OVERSAMPLE);

    // Last counter value of the half-bit start qualification window.
    localparam logic [CW-1:0] HALF_LAST = CW'(OVERSAMPLE / 2 - 1);
    // Last counter value of a full bit period.
    localparam logic [CW-1:0] BIT_LAST  = CW'(OVERSAMPLE - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    // ------------------------------------------------------------------
    // Input synchronizer
    // ------------------------------------------------------------------
    logic rx_meta;
    logic rx_s;

    // Two-flop synchronizer for the asynchronous rx line.
    always_ff @(posedge clk_in) begin
        // NOTE: both flops reset to 1 (the idle level) so that leaving reset
        // never looks like a falling start edge.
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments here make rx_s take the old
            // rx_meta; blocking ones would collapse the two stages into one.
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    // ------------------------------------------------------------------
    // Frame FSM and datapath state
    // ------------------------------------------------------------------
    state_t        state,   state_next;
    logic [CW-1:0] counter, counter_next;
    logic [2:0]    bitpos,  bitpos_next;
    logic          armed,   armed_next;
    logic [7:0]    shift,   shift_next;

    // Completion events, valid for exactly the cycle that samples the stop bit.
    logic          byte_good;
    logic          byte_bad;

    // FSM state register plus the counters and shift register it steers.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            state   <= IDLE;
            counter <= '0;
            bitpos  <= '0;
            armed   <= 1'b0;
            shift   <= '0;
        end else begin
            state   <= state_next;
            counter <= counter_next;
            bitpos  <= bitpos_next;
            armed   <= armed_next;
            shift   <= shift_next;
        end
    end

    // Next-state logic; nothing moves unless clken is high.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        state_next   = state;
        counter_next = counter;
        bitpos_next  = bitpos;
        armed_next   = armed;
        shift_next   = shift;
        byte_good    = 1'b0;
        byte_bad     = 1'b0;

        if (clken) begin
            case (state)
                IDLE: begin
                    counter_next = '0;
                    // A start edge only counts once the line has been seen
                    // high; this stops a line stuck low from re-triggering.
                    if (rx_s) begin
                        armed_next = 1'b1;
                    end else if (armed) begin
                        state_next = START;
                        armed_next = 1'b0;
                    end
                end

                START: begin
                    if (counter == HALF_LAST) begin
                        counter_next = '0;
                        if (!rx_s) begin
                            // Still low at mid start bit: a real start.
                            state_next  = DATA;
                            bitpos_next = '0;
                        end else begin
                            // Short low glitch: drop it without touching flags.
                            state_next = IDLE;
                        end
                    end else begin
                        counter_next = counter + 1'b1;
                    end
                end

                DATA: begin
                    if (counter == BIT_LAST) begin
                        counter_next       = '0;
                        shift_next[bitpos] = rx_s;
                        bitpos_next        = bitpos + 3'd1;
                        if (bitpos == 3'd7) begin
                            state_next = STOP;
                        end
                    end else begin
                        counter_next = counter + 1'b1;
                    end
                end

                STOP: begin
                    if (counter == BIT_LAST) begin
                        counter_next = '0;
                        state_next   = IDLE;
                        armed_next   = 1'b0;
                        if (rx_s) begin
                            byte_good = 1'b1;
                        end else begin
                            byte_bad = 1'b1;
                        end
                    end else begin
                        counter_next = counter + 1'b1;
                    end
                end

                default: begin
                    state_next   = IDLE;
                    counter_next = '0;
                    armed_next   = 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Consumer-facing outputs
    // ------------------------------------------------------------------
    logic [7:0] dout_next;
    logic       rdy_next;
    logic       frame_err_next;
    logic       overrun_next;

    // Output flags: rdy_clr clears first, then completion events override.
    always_comb begin
        dout_next      = dout;
        rdy_next       = rdy;
        frame_err_next = frame_err;
        overrun_next   = overrun;

        // The acknowledge is honoured whether or not clken is active.
        if (rdy_clr) begin
            rdy_next       = 1'b0;
            frame_err_next = 1'b0;
            overrun_next   = 1'b0;
        end

        // A good byte always lands in dout; it only counts as an overrun if
        // the previous byte is still unread and not being acknowledged now.
        if (byte_good) begin
            dout_next = shift;
            rdy_next  = 1'b1;
            if (rdy && !rdy_clr) begin
                overrun_next = 1'b1;
            end
        end

        // A bad stop bit discards the byte; dout and rdy keep their values.
        if (byte_bad) begin
            frame_err_next = 1'b1;
        end
    end

    // Output register for the received byte and the status flags.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            dout      <= 8'h00;
            rdy       <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            dout      <= dout_next;
            rdy       <= rdy_next;
            frame_err <= frame_err_next;
            overrun   <= overrun_next;
        end
    end

    assign rx_busy = (state != IDLE);

endmodule
